// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave):
// request/ack handshake with a doubleword-aligned address and byte-lane write mask.
interface mem_stage_if #(
  parameter int XLEN = 64
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [63:0]     dmem_wdata;
  logic [7:0]      dmem_wmask;
  logic            dmem_ack;
  logic [63:0]     dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// RV64 memory-access stage: issues loads/stores on the data bus, aligns and extends load
// data, and presents a registered result to writeback. Datapath assumes XLEN == 64.
module mem_stage #(
  parameter int XLEN     = 64,
  parameter int MEM_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [XLEN-1:0]     ex_result_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                rd_wen_i,
  output logic                stall_o,
  mem_stage_if.master         dmem,
  output logic                valid_o,
  output logic [4:0]          rd_addr_o,
  output logic                rd_wen_o,
  output logic [XLEN-1:0]     rd_data_o,
  output logic                misalign_o
);

  localparam logic [MEM_OP_W-1:0] OP_LB  = 4'h1;
  localparam logic [MEM_OP_W-1:0] OP_LH  = 4'h2;
  localparam logic [MEM_OP_W-1:0] OP_LW  = 4'h3;
  localparam logic [MEM_OP_W-1:0] OP_LD  = 4'h4;
  localparam logic [MEM_OP_W-1:0] OP_LBU = 4'h5;
  localparam logic [MEM_OP_W-1:0] OP_LHU = 4'h6;
  localparam logic [MEM_OP_W-1:0] OP_LWU = 4'h7;
  localparam logic [MEM_OP_W-1:0] OP_SB  = 4'h8;
  localparam logic [MEM_OP_W-1:0] OP_SH  = 4'h9;
  localparam logic [MEM_OP_W-1:0] OP_SW  = 4'hA;
  localparam logic [MEM_OP_W-1:0] OP_SD  = 4'hB;

  typedef enum logic {IDLE, BUS} state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [7:0]            wmask_q, wmask_d;
  logic [MEM_OP_W-1:0]   op_q, op_d;
  logic [2:0]            off_q, off_d;
  logic [4:0]            lat_rd_q, lat_rd_d;
  logic                  lat_wen_q, lat_wen_d;
  logic                  valid_q, valid_d;
  logic                  mis_q, mis_d;
  logic [4:0]            rd_addr_q, rd_addr_d;
  logic                  rd_wen_q, rd_wen_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;

  // Decode of the incoming op
  logic       is_mem, is_store, is_half, is_word, is_dword, misal;
  logic [2:0] off_in;
  logic [7:0] mask_in;

  assign off_in   = ex_result_i[2:0];
  assign is_mem   = (mem_op >= OP_LB) && (mem_op <= OP_SD);
  assign is_store = (mem_op >= OP_SB) && (mem_op <= OP_SD);
  assign is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
  assign is_word  = (mem_op == OP_LW) || (mem_op == OP_LWU) || (mem_op == OP_SW);
  assign is_dword = (mem_op == OP_LD) || (mem_op == OP_SD);
  assign misal    = (is_half && off_in[0]) || (is_word && (off_in[1:0] != 2'b00)) ||
                    (is_dword && (off_in != 3'b000));

  always_comb begin
    mask_in = 8'h00;
    case (mem_op)
      OP_SB:   mask_in = 8'h01 << off_in;
      OP_SH:   mask_in = 8'h03 << off_in;
      OP_SW:   mask_in = 8'h0F << off_in;
      OP_SD:   mask_in = 8'hFF;
      default: mask_in = 8'h00;
    endcase
  end

  // Load alignment and extension, using the op/offset latched at accept time
  logic [63:0] sh_rdata, load_val;

  assign sh_rdata = dmem.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = sh_rdata;
    case (op_q)
      OP_LB:   load_val = {{56{sh_rdata[7]}},  sh_rdata[7:0]};
      OP_LH:   load_val = {{48{sh_rdata[15]}}, sh_rdata[15:0]};
      OP_LW:   load_val = {{32{sh_rdata[31]}}, sh_rdata[31:0]};
      OP_LBU:  load_val = {56'd0, sh_rdata[7:0]};
      OP_LHU:  load_val = {48'd0, sh_rdata[15:0]};
      OP_LWU:  load_val = {32'd0, sh_rdata[31:0]};
      default: load_val = sh_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    op_d      = op_q;
    off_d     = off_q;
    lat_rd_d  = lat_rd_q;
    lat_wen_d = lat_wen_q;
    valid_d   = 1'b0;
    mis_d     = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_wen_d  = rd_wen_q;
    rd_data_d = rd_data_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (!is_mem) begin
            valid_d   = 1'b1;
            rd_data_d = ex_result_i;
            rd_addr_d = rd_addr_i;
            rd_wen_d  = rd_wen_i;
          end else if (misal) begin
            valid_d   = 1'b1;
            mis_d     = 1'b1;
            rd_data_d = '0;
            rd_addr_d = rd_addr_i;
            rd_wen_d  = 1'b0;
          end else begin
            state_d   = BUS;
            req_d     = 1'b1;
            we_d      = is_store;
            addr_d    = {ex_result_i[XLEN-1:3], 3'b000};
            wdata_d   = wdata_i[63:0] << {off_in, 3'b000};
            wmask_d   = mask_in;
            op_d      = mem_op;
            off_d     = off_in;
            lat_rd_d  = rd_addr_i;
            lat_wen_d = rd_wen_i;
          end
        end
      end
      BUS: begin
        // The ack cycle still stalls; the next upstream instruction is taken in IDLE.
        if (dmem.dmem_ack) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          wmask_d   = 8'h00;
          valid_d   = 1'b1;
          rd_addr_d = lat_rd_q;
          if (op_q >= OP_SB) begin
            rd_wen_d  = 1'b0;
            rd_data_d = '0;
          end else begin
            rd_wen_d  = lat_wen_q;
            rd_data_d = load_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= 8'h00;
      op_q      <= '0;
      off_q     <= 3'd0;
      lat_rd_q  <= 5'd0;
      lat_wen_q <= 1'b0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_wen_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      op_q      <= op_d;
      off_q     <= off_d;
      lat_rd_q  <= lat_rd_d;
      lat_wen_q <= lat_wen_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
      rd_addr_q <= rd_addr_d;
      rd_wen_q  <= rd_wen_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign stall_o          = (state_q == BUS);
  assign dmem.dmem_req    = req_q;
  assign dmem.dmem_we     = we_q;
  assign dmem.dmem_addr   = addr_q;
  assign dmem.dmem_wdata  = wdata_q;
  assign dmem.dmem_wmask  = wmask_q;
  assign valid_o          = valid_q;
  assign misalign_o       = mis_q;
  assign rd_addr_o        = rd_addr_q;
  assign rd_wen_o         = rd_wen_q;
  assign rd_data_o        = rd_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single instructions plus hand-written
// sequences for back-to-back issue during BUS, stray acks and reset mid-access.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  mem_op;
  logic [63:0] ex_result_i;
  logic [63:0] wdata_i;
  logic [4:0]  rd_addr_i;
  logic        rd_wen_i;
  logic        stall_o;
  logic        valid_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;
  logic [63:0] rd_data_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  mem_stage_if #(.XLEN(64)) bus ();

  mem_stage #(.XLEN(64), .MEM_OP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .mem_op      (mem_op),
    .ex_result_i (ex_result_i),
    .wdata_i     (wdata_i),
    .rd_addr_i   (rd_addr_i),
    .rd_wen_i    (rd_wen_i),
    .stall_o     (stall_o),
    .dmem        (bus),
    .valid_o     (valid_o),
    .rd_addr_o   (rd_addr_o),
    .rd_wen_o    (rd_wen_o),
    .rd_data_o   (rd_data_o),
    .misalign_o  (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [63:0] ex;
    logic [63:0] wd;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] rdata;
    int          nack;
    bit          use_bus;
    bit          we;
    logic [7:0]  mask;
    logic [63:0] bwdata;
    logic [63:0] data;
    bit          wen_o;
    bit          mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [3:0] op, logic [63:0] ex, logic [63:0] wd,
                              logic [4:0] rd, logic wen, logic [63:0] rdata, int nack,
                              bit use_bus, bit we, logic [7:0] mask, logic [63:0] bwdata,
                              logic [63:0] data, bit wen_o, bit mis);
    vec_t v;
    v.name = name; v.op = op; v.ex = ex; v.wd = wd; v.rd = rd; v.wen = wen;
    v.rdata = rdata; v.nack = nack; v.use_bus = use_bus; v.we = we; v.mask = mask;
    v.bwdata = bwdata; v.data = data; v.wen_o = wen_o; v.mis = mis;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v);
    @(negedge clk);
    valid_i = 1'b1; mem_op = v.op; ex_result_i = v.ex; wdata_i = v.wd;
    rd_addr_i = v.rd; rd_wen_i = v.wen;
    @(negedge clk);
    valid_i = 1'b0; mem_op = 4'h0;
    if (v.use_bus) begin
      chk({v.name, " we"},    64'(bus.dmem_we),    64'(v.we));
      chk({v.name, " addr"},  bus.dmem_addr,       {v.ex[63:3], 3'b000});
      chk({v.name, " wmask"}, 64'(bus.dmem_wmask), 64'(v.mask));
      chk({v.name, " wdata"}, bus.dmem_wdata,      v.bwdata);
      for (int k = 0; k <= v.nack; k++) begin
        chk({v.name, " stall"}, 64'(stall_o),       64'd1);
        chk({v.name, " req"},   64'(bus.dmem_req),  64'd1);
        chk({v.name, " hold"},  bus.dmem_addr,      {v.ex[63:3], 3'b000});
        chk({v.name, " early valid"}, 64'(valid_o), 64'd0);
        if (k == v.nack) begin
          bus.dmem_ack = 1'b1; bus.dmem_rdata = v.rdata;
        end
        @(negedge clk);
      end
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'd0;
    end
    chk({v.name, " req after"}, 64'(bus.dmem_req), 64'd0);
    chk({v.name, " stall after"}, 64'(stall_o),    64'd0);
    chk({v.name, " valid"},  64'(valid_o),    64'd1);
    chk({v.name, " mis"},    64'(misalign_o), 64'(v.mis));
    chk({v.name, " rd_wen"}, 64'(rd_wen_o),   64'(v.wen_o));
    if (!v.mis) begin
      chk({v.name, " rd_addr"}, 64'(rd_addr_o), 64'(v.rd));
      chk({v.name, " rd_data"}, rd_data_o,      v.data);
    end
    $display("vec %s: op=%h addr=%h rd_data=%h valid=%0d mis=%0d", v.name, v.op, v.ex,
             rd_data_o, valid_o, misalign_o);
    @(negedge clk);
    chk({v.name, " valid pulse"}, 64'(valid_o),    64'd0);
    chk({v.name, " mis pulse"},   64'(misalign_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; mem_op = 4'h0; ex_result_i = 64'd0; wdata_i = 64'd0;
    rd_addr_i = 5'd0; rd_wen_i = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'd0;

    //          name     op    ex                      wdata                   rd   wen rdata                   n  bus we mask   bwdata                  data                    weno mis
    vecs.push_back(mk("none",  4'h0, 64'h1234,             64'h0,                  5'd5, 1, 64'h0,                  0, 0, 0, 8'h00, 64'h0,                  64'h1234,               1, 0));
    vecs.push_back(mk("opC",   4'hC, 64'hDEAD_BEEF_0000_0001, 64'h0,               5'd7, 1, 64'h0,                  0, 0, 0, 8'h00, 64'h0,                  64'hDEAD_BEEF_0000_0001, 1, 0));
    vecs.push_back(mk("lb",    4'h1, 64'h1000_0003,        64'h0,                  5'd10,1, 64'h0000_0000_80FF_0000, 3, 1, 0, 8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 1, 0));
    vecs.push_back(mk("lhu",   4'h6, 64'h2006,             64'h0,                  5'd11,1, 64'h8001_1234_5678_9ABC, 0, 1, 0, 8'h00, 64'h0,                  64'h0000_0000_0000_8001, 1, 0));
    vecs.push_back(mk("sh",    4'h9, 64'h3002,             64'hBEEF,               5'd3, 1, 64'h0,                  1, 1, 1, 8'h0C, 64'hBEEF_0000,          64'h0,                  0, 0));
    vecs.push_back(mk("lw_mis",4'h3, 64'h4006,             64'h0,                  5'd4, 1, 64'h0,                  0, 0, 0, 8'h00, 64'h0,                  64'h0,                  0, 1));
    vecs.push_back(mk("ld",    4'h4, 64'h5008,             64'h0,                  5'd12,1, 64'h0123_4567_89AB_CDEF, 2, 1, 0, 8'h00, 64'h0,                  64'h0123_4567_89AB_CDEF, 1, 0));
    vecs.push_back(mk("lh",    4'h2, 64'h600E,             64'h0,                  5'd13,1, 64'h8001_0000_0000_0000, 0, 1, 0, 8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_8001, 1, 0));
    vecs.push_back(mk("lwu",   4'h7, 64'h7004,             64'h0,                  5'd14,1, 64'hF000_0001_0000_0000, 1, 1, 0, 8'h00, 64'h0,                  64'h0000_0000_F000_0001, 1, 0));
    vecs.push_back(mk("lw",    4'h3, 64'h7004,             64'h0,                  5'd15,1, 64'hF000_0001_0000_0000, 0, 1, 0, 8'h00, 64'h0,                  64'hFFFF_FFFF_F000_0001, 1, 0));
    vecs.push_back(mk("sb",    4'h8, 64'h8005,             64'hAA,                 5'd16,1, 64'h0,                  0, 1, 1, 8'h20, 64'h0000_AA00_0000_0000, 64'h0,                  0, 0));
    vecs.push_back(mk("sw",    4'hA, 64'h9004,             64'h1122_3344,          5'd17,1, 64'h0,                  2, 1, 1, 8'hF0, 64'h1122_3344_0000_0000, 64'h0,                  0, 0));
    vecs.push_back(mk("sd",    4'hB, 64'hA000,             64'hCAFE_F00D_1234_5678, 5'd18,1, 64'h0,                 0, 1, 1, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0,                  0, 0));
    vecs.push_back(mk("sd_mis",4'hB, 64'hA004,             64'h1,                  5'd19,1, 64'h0,                  0, 0, 0, 8'h00, 64'h0,                  64'h0,                  0, 1));
    vecs.push_back(mk("lh_mis",4'h2, 64'h0001,             64'h0,                  5'd20,1, 64'h0,                  0, 0, 0, 8'h00, 64'h0,                  64'h0,                  0, 1));
    vecs.push_back(mk("lb7",   4'h1, 64'h0007,             64'h0,                  5'd21,1, 64'h7F00_0000_0000_0000, 0, 1, 0, 8'h00, 64'h0,                  64'h0000_0000_0000_007F, 1, 0));
    vecs.push_back(mk("lbu",   4'h5, 64'hB001,             64'h0,                  5'd22,1, 64'h0000_0000_0000_FF00, 0, 1, 0, 8'h00, 64'h0,                  64'h0000_0000_0000_00FF, 1, 0));
    vecs.push_back(mk("none0", 4'h0, 64'hFFFF_0000_FFFF_0000, 64'h0,               5'd0, 0, 64'h0,                  0, 0, 0, 8'h00, 64'h0,                  64'hFFFF_0000_FFFF_0000, 0, 0));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst valid",   64'(valid_o),         64'd0);
    chk("rst rd_wen",  64'(rd_wen_o),        64'd0);
    chk("rst mis",     64'(misalign_o),      64'd0);
    chk("rst req",     64'(bus.dmem_req),    64'd0);
    chk("rst we",      64'(bus.dmem_we),     64'd0);
    chk("rst wmask",   64'(bus.dmem_wmask),  64'd0);
    chk("rst rd_addr", 64'(rd_addr_o),       64'd0);
    chk("rst rd_data", rd_data_o,            64'd0);
    chk("rst stall",   64'(stall_o),         64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Instruction held upstream during BUS is taken in the first IDLE cycle after ack
    @(negedge clk);
    valid_i = 1'b1; mem_op = 4'h4; ex_result_i = 64'hC000; rd_addr_i = 5'd4; rd_wen_i = 1'b1;
    @(negedge clk);
    mem_op = 4'h0; ex_result_i = 64'h55; rd_addr_i = 5'd9;
    chk("bb stall", 64'(stall_o), 64'd1);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'd0;
    chk("bb ld valid", 64'(valid_o), 64'd1);
    chk("bb ld data",  rd_data_o,    64'h1111_2222_3333_4444);
    chk("bb ld rd",    64'(rd_addr_o), 64'd4);
    chk("bb idle",     64'(stall_o), 64'd0);
    @(negedge clk);
    valid_i = 1'b0;
    chk("bb none valid", 64'(valid_o), 64'd1);
    chk("bb none data",  rd_data_o,    64'h55);
    chk("bb none rd",    64'(rd_addr_o), 64'd9);
    $display("seq back-to-back: second result %h rd=%0d", rd_data_o, rd_addr_o);
    @(negedge clk);
    chk("bb pulse", 64'(valid_o), 64'd0);

    // Stray ack while IDLE is ignored
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'd0;
    chk("idle ack valid", 64'(valid_o), 64'd0);
    chk("idle ack stall", 64'(stall_o), 64'd0);
    chk("idle ack req",   64'(bus.dmem_req), 64'd0);
    $display("seq idle ack: valid=%0d stall=%0d", valid_o, stall_o);

    // Reset while BUS aborts the access; a later ack produces nothing
    @(negedge clk);
    valid_i = 1'b1; mem_op = 4'hB; ex_result_i = 64'hD000; wdata_i = 64'h77; rd_addr_i = 5'd1;
    @(negedge clk);
    valid_i = 1'b0; mem_op = 4'h0;
    chk("rb req", 64'(bus.dmem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rb req clr", 64'(bus.dmem_req), 64'd0);
    chk("rb stall",   64'(stall_o),      64'd0);
    chk("rb valid",   64'(valid_o),      64'd0);
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk("rb stray valid", 64'(valid_o),      64'd0);
    chk("rb stray req",   64'(bus.dmem_req), 64'd0);
    chk("rb stray stall", 64'(stall_o),      64'd0);
    $display("seq reset in BUS: req=%0d valid=%0d", bus.dmem_req, valid_o);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
